// File: rtl/snax_mx_seq_pkg.sv
// Shared types and constants for the MX job sequencer.
package snax_mx_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam int unsigned CsrPrec   = 0;
  localparam int unsigned CsrAccCnt = 1;
  localparam int unsigned CsrOutCnt = 2;

  // Bit of shell status word 0 that carries BUSY.
  localparam int unsigned BusyBit = 0;

endpackage

// File: rtl/snax_mx_desc_fifo.sv
// Descriptor queue: power-of-two depth, fall-through head, push refused when full.
module snax_mx_desc_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 128
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [LvlW-1:0]  level_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rptr_q];

  // Full is checked alone so a same-cycle pop never frees room for a push.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/snax_mx_job_sequencer.sv
// Launches queued descriptors on the MX shell CSR handshake, tracks completion
// via the shell busy flag, and halts the queue on a watchdog timeout.
//
// state  | meaning
// IDLE   | waiting for a queued descriptor
// LAUNCH | presenting head descriptor until the shell accepts
// RUN    | job in flight, watching busy and the watchdog
// HALT   | watchdog fired; no launches until clear_i
module snax_mx_job_sequencer
  import snax_mx_seq_pkg::*;
#(
  parameter int unsigned RegRWCount    = 4,
  parameter int unsigned RegDataWidth  = 32,
  parameter int unsigned QueueDepth    = 4,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [RegRWCount-1:0][RegDataWidth-1:0]   desc_i,
  input  logic                                      desc_valid_i,
  output logic                                      desc_ready_o,
  output logic [RegRWCount-1:0][RegDataWidth-1:0]   csr_reg_set_o,
  output logic                                      csr_reg_set_valid_o,
  input  logic                                      csr_reg_set_ready_i,
  input  logic [1:0][RegDataWidth-1:0]              csr_reg_ro_set_i,
  input  logic                                      clear_i,
  output logic [$clog2(QueueDepth):0]               queue_level_o,
  output logic [31:0]                               jobs_done_o,
  output logic [31:0]                               last_cycles_o,
  output logic                                      done_pulse_o,
  output logic                                      err_o
);

  localparam int unsigned DescW = RegRWCount * RegDataWidth;
  localparam logic [31:0] WdogLimit = (TimeoutCycles == 0) ? 32'd0 : 32'(TimeoutCycles - 1);

  state_t       state_q, state_d;
  logic [31:0]  wdog_q, wdog_d;
  logic [31:0]  jobs_q, jobs_d;
  logic [31:0]  last_q, last_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [DescW-1:0] head;
  logic             busy, run_armed, complete, timeout;
  logic             unused_ro;

  snax_mx_desc_fifo #(
    .Depth (QueueDepth),
    .Width (DescW)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (desc_valid_i),
    .data_i  (desc_i),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (queue_level_o)
  );

  assign desc_ready_o        = ~fifo_full;
  assign csr_reg_set_valid_o = (state_q == LAUNCH);
  assign csr_reg_set_o       = (state_q == LAUNCH) ? head : '0;

  assign busy      = csr_reg_ro_set_i[0][BusyBit];
  assign unused_ro = ^csr_reg_ro_set_i[0];

  // The watchdog count doubles as the "past first RUN cycle" flag: the shell
  // only shows BUSY one cycle after the handshake edge.
  assign run_armed = (wdog_q != '0);
  assign complete  = (state_q == RUN) && run_armed && !busy;
  assign timeout   = (TimeoutCycles != 0) && (state_q == RUN) && !complete &&
                     (wdog_q >= WdogLimit);

  always_comb begin
    state_d  = state_q;
    wdog_d   = wdog_q;
    jobs_d   = jobs_q;
    last_d   = last_q;
    done_d   = 1'b0;
    err_d    = err_q;
    fifo_pop = 1'b0;
    if (clear_i) err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = LAUNCH;
      end
      LAUNCH: begin
        if (csr_reg_set_ready_i) begin
          fifo_pop = 1'b1;
          wdog_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (complete) begin
          last_d  = 32'(csr_reg_ro_set_i[1]);
          jobs_d  = jobs_q + 32'd1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      HALT: begin
        if (clear_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wdog_q  <= '0;
      jobs_q  <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      jobs_q  <= jobs_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign jobs_done_o   = jobs_q;
  assign last_cycles_o = last_q;
  assign done_pulse_o  = done_q;
  assign err_o         = err_q;

endmodule

// File: doc/snax_mx_job_sequencer.md
# snax_mx_job_sequencer

Job sequencer for the MX tensor core shell. It accepts queued job descriptors from the host, launches them one at a time on the shell's CSR handshake, and detects completion from the shell's busy flag. On each completion it captures the shell's performance counter and reports job status. A watchdog halts the queue if a job stalls.

## Interface
- RegRWCount, 4, words per descriptor; matches the shell CSR RW set.
- RegDataWidth, 32, width of each descriptor word.
- QueueDepth, 4, number of descriptor entries; power of two, ≥2.
- TimeoutCycles, 0, watchdog limit in RUN state; 0 disables the watchdog.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- desc_i  in  [RegRWCount-1:0][RegDataWidth-1:0]  descriptor: word0 precision mode, word1 accumulation count, word2 output count, word3 reserved.
- desc_valid_i  in  1  descriptor push request.
- desc_ready_o  out  1  queue not full.
- csr_reg_set_o  out  [RegRWCount-1:0][RegDataWidth-1:0]  descriptor presented to the shell.
- csr_reg_set_valid_o  out  1  launch request to the shell.
- csr_reg_set_ready_i  in  1  shell idle and accepting.
- csr_reg_ro_set_i  in  [1:0][RegDataWidth-1:0]  shell status: [0][0] is busy, [1] is the performance counter.
- clear_i  in  1  clears err_o and leaves HALT.
- queue_level_o  out  $clog2(QueueDepth)+1  number of occupied queue entries.
- jobs_done_o  out  32  completed-job count; wraps at 2^32.
- last_cycles_o  out  32  performance counter value captured at the last completion.
- done_pulse_o  out  1  one-cycle pulse per completed job.
- err_o  out  1  sticky watchdog error.

## Operation
- Queue
  - Push when desc_valid_i && desc_ready_o; desc_ready_o = (level != QueueDepth).
  - A push into a full queue is never accepted, even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves the level unchanged.
  - A pushed entry becomes visible at the head one cycle after the push.
- FSM, states IDLE, LAUNCH, RUN, HALT.
  - IDLE: if the queue is non-empty, go to LAUNCH.
  - LAUNCH:
    - csr_reg_set_valid_o = 1 and csr_reg_set_o = head entry; hold both stable until ready.
    - On valid && ready: pop the head, clear the watchdog counter, go to RUN.
  - RUN:
    - The first RUN cycle ignores busy, because the shell registers BUSY on the handshake edge.
    - From the second RUN cycle, busy == 0 means completion:
      - capture csr_reg_ro_set_i[1] into last_cycles_o;
      - jobs_done_o += 1;
      - done_pulse_o = 1 for that cycle;
      - go to IDLE.
  - Watchdog (TimeoutCycles != 0): if RUN lasts TimeoutCycles cycles without completion, set err_o and go to HALT.
  - HALT:
    - No launches; queue pushes are still accepted.
    - clear_i clears err_o and returns to IDLE.
    - A job still running on the shell is not aborted. Its later completion is not counted.
  - clear_i outside HALT clears err_o only.
- csr_reg_set_o is '0 whenever csr_reg_set_valid_o is 0.
- Descriptor contents are passed through unmodified; no validation is performed.

## Timing
- Reset values:
  - all outputs 0, except desc_ready_o = 1;
  - queue empty, FSM in IDLE.
- Reset mid-operation abandons the queue and any in-flight job.
- Latency from first push into an empty queue with an idle shell:
  - cycle 0: push;
  - cycle 1: IDLE sees the non-empty queue;
  - cycle 2: LAUNCH, valid high, handshake.
- Completion pulse: one cycle after the shell's busy is sampled low in RUN.
- Back-to-back jobs: at least 2 idle cycles between a completion and the next handshake (RUN → IDLE → LAUNCH).
- The watchdog counter saturates and does not wrap.
- jobs_done_o wraps from 0xFFFFFFFF to 0.

## Structure
- Package snax_mx_seq_pkg:
  - state_t enum (IDLE, LAUNCH, RUN, HALT);
  - CSR word index constants (CsrPrec = 0, CsrAccCnt = 1, CsrOutCnt = 2);
  - busy bit index.
- Sub-module snax_mx_desc_fifo: parameterized depth and width; ports for push, pop, full, empty and level; head output not registered (fall-through on read).
- The FSM, watchdog and status registers live in the top module.

## Test plan
- Single job:
  - stimulus: push {prec=0x05, acc=4, out=2}; the shell model is busy for 20 cycles after the handshake and reports perf = 20;
  - required: handshake in the 2nd cycle after the push; one done_pulse_o; jobs_done_o = 1; last_cycles_o = 20.
- Queue fill:
  - stimulus: with the shell stalled (ready = 0), push 5 descriptors;
  - required: 4 accepted, desc_ready_o = 0 and queue_level_o = 4 after the fourth; the fifth is held until a pop.
- Three back-to-back jobs:
  - stimulus: jobs with perf 7, 9 and 3;
  - required: launched in FIFO order with no descriptor corruption; last_cycles_o ends at 3; jobs_done_o = 3.
- One-cycle busy:
  - stimulus: output count 0, so the shell is busy for only 1 cycle;
  - required: completion is detected exactly once, with no hang and no double count.
- Watchdog:
  - stimulus: TimeoutCycles = 50 and the shell stays busy;
  - required: err_o rises after 50 RUN cycles, no further launches, and clear_i returns the FSM to IDLE.
- Reset mid-run:
  - stimulus: assert rst_ni low while in RUN with 2 entries queued;
  - required: all outputs return to their reset values immediately and the queue is empty.
